// File: rtl/wavegen_pkg.sv
// wavegen_pkg: shared types and constants for the wavegen voice path.
// Provides the envelope state encoding, the fixed envelope rate tables
// (samples per level step) and the envelope full-scale level.
package wavegen_pkg;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } env_state_t;

  // Attack samples-per-step, indexed by the 4-bit attack rate.
  localparam logic [12:0] ENV_ATK_PERIOD [16] = '{
    13'd1,   13'd2,   13'd3,   13'd5,   13'd7,   13'd11,  13'd13,  13'd15,
    13'd19,  13'd47,  13'd94,  13'd151, 13'd188, 13'd565, 13'd941, 13'd1506
  };

  // Decay/release samples-per-step: three times the attack table.
  localparam logic [12:0] ENV_DR_PERIOD [16] = '{
    13'd3,   13'd6,   13'd9,    13'd15,   13'd21,   13'd33,   13'd39,   13'd45,
    13'd57,  13'd141, 13'd282,  13'd453,  13'd564,  13'd1695, 13'd2823, 13'd4518
  };

  localparam logic [7:0] ENV_MAX = 8'd255;

endpackage

// File: rtl/wavegen_env_rate.sv
// wavegen_env_rate: envelope rate prescaler.
// Looks up the samples-per-step period for the current envelope state and
// counts strobes; pulses step when the period has elapsed.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   sample_strobe    48 kHz sample pulse; the counter only moves on it
//   state            current envelope state
//   attack, decay,
//   release_rate     4-bit rate indices, sampled live
//   clear            restart the count (envelope state is changing)
//   hold             keep the counter at 0 and suppress steps (idle)
//   step             one-cycle step pulse, coincident with a strobe
module wavegen_env_rate
  import wavegen_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sample_strobe,
  input  env_state_t state,
  input  logic [3:0] attack,
  input  logic [3:0] decay,
  input  logic [3:0] release_rate,
  input  logic       clear,
  input  logic       hold,
  output logic       step
);

  logic [12:0] period;
  logic [12:0] cnt_q;
  logic        last;

  always_comb begin
    period = ENV_DR_PERIOD[decay];
    case (state)
      StAttack:  period = ENV_ATK_PERIOD[attack];
      StRelease: period = ENV_DR_PERIOD[release_rate];
      default:   period = ENV_DR_PERIOD[decay];
    endcase
  end

  // >= rather than == so that shortening the rate mid-phase steps at the
  // next compare instead of letting the counter run on past the new period.
  assign last = (cnt_q >= (period - 13'd1));
  assign step = sample_strobe & ~hold & last;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (sample_strobe) begin
      if (clear || hold || last) cnt_q <= '0;
      else                       cnt_q <= cnt_q + 13'd1;
    end
  end

endmodule

// File: rtl/wavegen_env.sv
// wavegen_env: per-voice ADSR envelope generator and VCA.
// Ports:
//   clk, rst_n       clock, synchronous active-low reset
//   sample_strobe    48 kHz sample pulse; all state advances only on it
//   gate             voice GATE bit
//   attack, decay    attack / decay rate indices
//   sustain          sustain level nibble (level = sustain * 17)
//   release_rate     release rate index ('release' is a reserved word)
//   sample_in        signed oscillator sample
//   sample_out       signed enveloped sample, one strobe of latency
//   env_level        envelope level 0..255
//   env_state        envelope state (env_state_t encoding)
module wavegen_env
  import wavegen_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sample_strobe,
  input  logic        gate,
  input  logic [3:0]  attack,
  input  logic [3:0]  decay,
  input  logic [3:0]  sustain,
  input  logic [3:0]  release_rate,
  input  logic [15:0] sample_in,
  output logic [15:0] sample_out,
  output logic [7:0]  env_level,
  output logic [2:0]  env_state
);

  env_state_t  state_q, state_d;
  logic [7:0]  level_q, level_d;
  logic        gate_q;
  logic [15:0] sample_out_q;
  logic        rise, fall, step, clear, hold;
  logic [7:0]  sus_lvl;
  logic signed [24:0] prod;
  logic        unused_prod;

  assign rise    = gate & ~gate_q;
  assign fall    = ~gate & gate_q;
  assign sus_lvl = {sustain, sustain};
  assign hold    = (state_q == StIdle);
  assign clear   = (state_d != state_q);

  wavegen_env_rate u_rate (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_strobe (sample_strobe),
    .state         (state_q),
    .attack        (attack),
    .decay         (decay),
    .release_rate  (release_rate),
    .clear         (clear),
    .hold          (hold),
    .step          (step)
  );

  // Gate edges win over rate steps; a re-trigger keeps the current level.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (rise) begin
      state_d = StAttack;
    end else if (fall && (state_q != StIdle)) begin
      state_d = StRelease;
    end else begin
      case (state_q)
        StAttack: begin
          if (step) begin
            if (level_q >= 8'd254) begin
              level_d = ENV_MAX;
              state_d = StDecay;
            end else begin
              level_d = level_q + 8'd1;
            end
          end
        end
        StDecay: begin
          if (step) begin
            if (level_q <= sus_lvl) state_d = StSustain;
            else                    level_d = level_q - 8'd1;
          end
        end
        StSustain: begin
          if (step && (level_q > sus_lvl)) state_d = StDecay;
        end
        StRelease: begin
          if (level_q == 8'd0) begin
            state_d = StIdle;
          end else if (step) begin
            level_d = level_q - 8'd1;
            if (level_q == 8'd1) state_d = StIdle;
          end
        end
        default: begin
          state_d = StIdle;
          level_d = level_q;
        end
      endcase
    end
  end

  // Level is zero-extended so the 9-bit factor is always non-negative.
  assign prod        = $signed(sample_in) * $signed({1'b0, level_q});
  assign unused_prod = ^{prod[24], prod[7:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      level_q      <= '0;
      gate_q       <= 1'b0;
      sample_out_q <= '0;
    end else if (sample_strobe) begin
      state_q      <= state_d;
      level_q      <= level_d;
      gate_q       <= gate;
      sample_out_q <= prod[23:8];
    end
  end

  assign sample_out = sample_out_q;
  assign env_level  = level_q;
  assign env_state  = state_q;

endmodule

// File: tb/tb_wavegen_env.sv
module tb_wavegen_env;
  import wavegen_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sample_strobe = 1'b0;
  logic        gate = 1'b0;
  logic [3:0]  attack = '0, decay = '0, sustain = '0, release_rate = '0;
  logic [15:0] sample_in = '0;
  logic [15:0] sample_out;
  logic [7:0]  env_level;
  logic [2:0]  env_state;

  always #5 clk = ~clk;

  wavegen_env dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sample_strobe (sample_strobe),
    .gate          (gate),
    .attack        (attack),
    .decay         (decay),
    .sustain       (sustain),
    .release_rate  (release_rate),
    .sample_in     (sample_in),
    .sample_out    (sample_out),
    .env_level     (env_level),
    .env_state     (env_state)
  );

  typedef struct {
    string       name;
    logic [2:0]  st;
    logic [7:0]  lvl;
    logic [15:0] out;
  } exp_t;

  exp_t       sb_q[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] last_lvl = '0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    end
  endtask

  // Queue the expected post-strobe outputs, then issue one strobe.
  task automatic tick(input string name, input logic [2:0] st, input logic [7:0] lvl,
                      input logic [15:0] out);
    exp_t e;
    e.name = name; e.st = st; e.lvl = lvl; e.out = out;
    sb_q.push_back(e);
    last_lvl = lvl;
    @(negedge clk) sample_strobe = 1'b1;
    @(negedge clk) sample_strobe = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // With sample_in = 0x0100 the VCA output equals the previous level.
  task automatic tick_u(input string name, input logic [2:0] st, input logic [7:0] lvl);
    tick(name, st, lvl, {8'h00, last_lvl});
  endtask

  // Monitor: compare on every strobe the DUT accepts.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      if (sample_strobe && rst_n) begin
        #1;
        if (sb_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_strobe: got a strobe, expected none queued");
        end else begin
          e = sb_q.pop_front();
          check({e.name, "_state"}, 32'(env_state), 32'(e.st));
          check({e.name, "_level"}, 32'(env_level), 32'(e.lvl));
          check({e.name, "_out"}, 32'(sample_out), 32'(e.out));
        end
      end
    end
  end

  initial begin : stim
    repeat (3) @(negedge clk);
    check("reset_state", 32'(env_state), 32'(StIdle));
    check("reset_level", 32'(env_level), 32'd0);
    check("reset_out", 32'(sample_out), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Idle with a non-zero input: nothing moves.
    sample_in = 16'h4000;
    for (int i = 0; i < 100; i++) tick("idle", StIdle, 8'd0, 16'h0000);

    // Full ADSR with fastest rates, sustain 8 -> 136.
    attack = 4'd0; decay = 4'd0; sustain = 4'd8; release_rate = 4'd0;
    sample_in = 16'h0100;
    gate = 1'b1;
    tick_u("atk_start", StAttack, 8'd0);
    for (int k = 1; k <= 254; k++) tick_u("atk", StAttack, 8'(k));
    tick_u("atk_top", StDecay, 8'd255);
    for (int l = 254; l >= 136; l--) begin
      tick_u("dec_hold", StDecay, 8'(l + 1));
      tick_u("dec_hold", StDecay, 8'(l + 1));
      tick_u("dec_step", StDecay, 8'(l));
    end
    tick_u("dec_hold", StDecay, 8'd136);
    tick_u("dec_hold", StDecay, 8'd136);
    tick_u("sus_enter", StSustain, 8'd136);
    repeat (10) tick_u("sus_hold", StSustain, 8'd136);

    // Release from 136 at 3 strobes per step: 408 strobes to idle.
    gate = 1'b0;
    tick_u("rel_enter", StRelease, 8'd136);
    for (int l = 135; l >= 1; l--) begin
      tick_u("rel_hold", StRelease, 8'(l + 1));
      tick_u("rel_hold", StRelease, 8'(l + 1));
      tick_u("rel_step", StRelease, 8'(l));
    end
    tick_u("rel_hold", StRelease, 8'd1);
    tick_u("rel_hold", StRelease, 8'd1);
    tick_u("rel_idle", StIdle, 8'd0);
    repeat (5) tick_u("idle2", StIdle, 8'd0);

    // attack=9: exactly 47 strobes per step.
    attack = 4'd9;
    gate = 1'b1;
    tick_u("a9_start", StAttack, 8'd0);
    for (int s = 1; s <= 2; s++) begin
      repeat (46) tick_u("a9_hold", StAttack, 8'(s - 1));
      tick_u("a9_step", StAttack, 8'(s));
    end
    repeat (20) tick_u("a9_mid", StAttack, 8'd2);
    // Mid-phase rate change: steps every strobe from the next one.
    attack = 4'd0;
    for (int l = 3; l <= 60; l++) tick_u("a0_fast", StAttack, 8'(l));

    // Re-trigger during release resumes from the current level.
    gate = 1'b0;
    tick_u("rel60", StRelease, 8'd60);
    gate = 1'b1;
    tick_u("reatk60", StAttack, 8'd60);
    for (int l = 61; l <= 254; l++) tick_u("reatk", StAttack, 8'(l));
    decay = 4'd15;
    tick_u("atk_full", StDecay, 8'd255);

    // VCA corners at level 255.
    sample_in = 16'h7FFF;
    tick("vca_pos", StDecay, 8'd255, 16'h7F7F);
    repeat (5) @(negedge clk);
    check("stable_level", 32'(env_level), 32'd255);
    check("stable_out", 32'(sample_out), 32'h7F7F);
    sample_in = 16'h8000;
    tick("vca_neg", StDecay, 8'd255, 16'h8080);

    sample_in = 16'h0100;
    gate = 1'b0;
    tick_u("rel255", StRelease, 8'd255);
    for (int l = 254; l >= 128; l--) begin
      tick_u("rel2_hold", StRelease, 8'(l + 1));
      tick_u("rel2_hold", StRelease, 8'(l + 1));
      tick_u("rel2_step", StRelease, 8'(l));
    end
    sample_in = 16'hFFFF;
    tick("vca_half", StRelease, 8'd128, 16'hFFFF);
    sample_in = 16'h0100;
    tick_u("rel2_hold", StRelease, 8'd128);

    // Reset mid-envelope without a strobe.
    @(negedge clk) rst_n = 1'b0;
    @(negedge clk);
    check("midrst_state", 32'(env_state), 32'(StIdle));
    check("midrst_level", 32'(env_level), 32'd0);
    check("midrst_out", 32'(sample_out), 32'd0);
    rst_n = 1'b1;
    last_lvl = 8'd0;
    tick_u("post_rst_idle", StIdle, 8'd0);
    gate = 1'b1;
    tick_u("post_rst_rise", StAttack, 8'd0);

    for (int i = 0; i < 100 && sb_q.size() != 0; i++) @(negedge clk);
    if (sb_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain: got %0d pending, expected 0", sb_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wavegen_env.md
# wavegen_env

Per-voice ADSR envelope generator and VCA for the Audrey voice path. It sits directly downstream of `wavegen_osc`: it consumes the oscillator's signed 16-bit `sample_out` and the GATE bit (`wave_ctrl[0]`). It produces the enveloped voice sample for the mixer. All state advances only on the 48 kHz `sample_strobe`.

## Interface
- No parameters. Rate tables are fixed constants in the package.
- `clk` in 1: system clock.
- `rst_n` in 1: reset, synchronous, active-low.
- `sample_strobe` in 1: one-cycle pulse per 48 kHz sample; same strobe as the oscillator.
- `gate` in 1: GATE, from `wave_ctrl[0]`.
- `attack` in 4: attack rate index.
- `decay` in 4: decay rate index.
- `sustain` in 4: sustain level nibble.
- `release` in 4: release rate index.
- `sample_in` in 16: signed oscillator sample.
- `sample_out` out 16: signed enveloped sample.
- `env_level` out 8: current envelope level, 0..255.
- `env_state` out 3: current state, encoded as `env_state_t`.

## Operation
- States:
  - IDLE = 0
  - ATTACK = 1
  - DECAY = 2
  - SUSTAIN = 3
  - RELEASE = 4
- Gate edge detection: `gate_d` is registered on each strobe. A rise is `gate & ~gate_d`; a fall is `~gate & gate_d`. Both are evaluated only on strobe cycles.
- Gate rise, from any state:
  - Enter ATTACK.
  - Level is NOT reset; attack resumes from the current level.
- Gate fall, from any state other than IDLE: enter RELEASE.
- Gate edges take priority over rate steps in the same strobe.
- Rate prescaler:
  - 13-bit counter advances on each strobe.
  - When counter == period−1, a "step" fires and the counter clears.
  - The counter clears on every state change.
  - Period is looked up from the current state's 4-bit index. Indices are sampled live, so a mid-phase change takes effect at the next compare.
- Attack periods (samples per step), index 0..15: 1, 2, 3, 5, 7, 11, 13, 15, 19, 47, 94, 151, 188, 565, 941, 1506.
- Decay/release periods are 3× the attack periods: 3, 6, 9, 15, 21, 33, 39, 45, 57, 141, 282, 453, 564, 1695, 2823, 4518.
- Per-state step behaviour:
  - ATTACK: level+1. If the level before the step is ≥254, the level becomes 255 and the state becomes DECAY.
  - DECAY: sus_lvl = {sustain, sustain}, i.e. sustain×17. If level ≤ sus_lvl, enter SUSTAIN without decrementing; otherwise level−1.
  - SUSTAIN: level holds. If level > sus_lvl (sustain lowered), re-enter DECAY. Raising sustain does not raise the level.
  - RELEASE: level−1. Entering IDLE when the result is 0. If already 0, go to IDLE without a step.
  - IDLE: level holds at 0, the counter is held at 0, and there are no steps.
- VCA:
  - Product = signed `sample_in` × zero-extended {1'b0, `env_level`}: 16×9 signed, 25-bit result.
  - `sample_out` = product[23:8], an arithmetic >>8 (floor).
  - Level 255 gives in×255/256; level 0 gives 0.

## Timing
- Reset values:
  - `sample_out` = 0
  - `env_level` = 0
  - `env_state` = IDLE
  - prescaler = 0
  - `gate_d` = 0
- All registers update only when `sample_strobe` = 1; between strobes all outputs are stable.
- VCA latency is one strobe. `sample_out` is computed from `sample_in` and the pre-update `env_level` on the same strobe edge.
- Gate edge to state change: the same strobe as the edge is seen. `env_state` changes on that strobe edge; the first level step occurs ≥1 strobe later.
- Reset asserted mid-envelope: everything returns to reset values on the next clk edge, regardless of strobe.

## Structure
- `wavegen_pkg` contains:
  - `typedef enum logic [2:0] env_state_t` (IDLE..RELEASE)
  - `ENV_ATK_PERIOD[16]` and `ENV_DR_PERIOD[16]` as 13-bit constant arrays
  - `ENV_MAX = 8'd255`
- Sub-module `wavegen_env_rate` contains:
  - the period lookup (state + 4 indices → period)
  - the 13-bit prescaler with clear/hold inputs
  - the `step` output
- `wavegen_env` contains the FSM, level register, gate edge detection and the VCA multiply.

## Test plan
- Reset, then gate=0 with sample_in=0x4000 for 100 strobes → `env_state`=IDLE, `env_level`=0, `sample_out`=0 throughout.
- attack=0, decay=0, sustain=8, release=0; raise gate:
  - expect ATTACK with level +1 per strobe, reaching 255 and DECAY 255 strobes later;
  - then −1 every 3 strobes down to 136 (0x88), then SUSTAIN, holding 136.
- Lower gate in SUSTAIN at level 136 with release=0 → RELEASE, level reaches 0 after 408 strobes, then IDLE.
- attack=9: confirm exactly 47 strobes per level step. Change attack to 0 mid-phase: subsequent steps occur every strobe.
- Raise gate during RELEASE at level 60 → ATTACK, resuming upward from 60 (no drop to 0).
- VCA at level 255:
  - sample_in=0x7FFF → 0x7F7F;
  - sample_in=0x8000 → 0x8080 (−32640);
  - at level 128, sample_in=0xFFFF → 0xFFFF (floor of −0.5).
